// File: rtl/sensor_stream_gen.sv
// sensor_stream_gen: NUM_CHANNELS synthetic sample streams, each paced by its own
// period timer (channel k period = BASE_PERIOD*(k+1)). Each stream has a ready/ack
// handshake and a sticky overrun flag.
// Optional feature macro: SENSOR_STREAM_GEN_LFSR_EN selects Galois-LFSR sample
// sequences (seed k+1) instead of the default ramp of step k+1.
module sensor_stream_gen #(
    parameter int unsigned NUM_CHANNELS = 8,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned TIMER_WIDTH  = 16,
    parameter int unsigned BASE_PERIOD  = 100
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [NUM_CHANNELS-1:0]            sensor_stream_ack,
    input  logic                               overrun_clear,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] sensor_stream,
    output logic [NUM_CHANNELS-1:0]            sensor_stream_ready,
    output logic [NUM_CHANNELS-1:0]            sensor_overrun,
    output logic                               running
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_t;

    state_t state;
    state_t next_state;

    logic [TIMER_WIDTH-1:0]  timer [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] expiry;

    function automatic logic [TIMER_WIDTH-1:0] reload_value(input int unsigned k);
        return TIMER_WIDTH'(BASE_PERIOD * (k + 1) - 1);
    endfunction

`ifdef SENSOR_STREAM_GEN_LFSR_EN
    // Right-shifting Galois feedback masks, maximal length for each width
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        case (width)
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0E08;
            13:      return 32'h0000_1C80;
            14:      return 32'h0000_3802;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0007_2000;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            default: return 32'h8020_0003;
        endcase
    endfunction

    localparam logic [31:0]           TAPS_FULL = lfsr_taps(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] TAPS      = TAPS_FULL[DATA_WIDTH-1:0];

    function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction
`endif

    // State register; running is registered alongside so it mirrors the RUN state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= next_state;
            running <= (next_state == RUN);
        end
    end

    // Next-state decode: ARM always lasts exactly one cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = ARM;
            ARM:     next_state = RUN;
            RUN:     if (!enable) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A channel expires when its timer has counted down to zero while actively running
    always_comb begin
        expiry = '0;
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            expiry[k] = (state == RUN) && enable && (timer[k] == '0);
        end
    end

    // Period timers: loaded in ARM, count down in RUN, frozen otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
                timer[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
                if (state == ARM) begin
                    timer[k] <= reload_value(k);
                end else if ((state == RUN) && enable) begin
                    if (expiry[k]) begin
                        timer[k] <= reload_value(k);
                    end else begin
                        timer[k] <= timer[k] - 1'b1;
                    end
                end
            end
        end
    end

    // Sample, ready and overrun per channel; acks are honoured in every state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
`ifdef SENSOR_STREAM_GEN_LFSR_EN
                sensor_stream[k*DATA_WIDTH +: DATA_WIDTH] <= DATA_WIDTH'(k + 1);
`else
                sensor_stream[k*DATA_WIDTH +: DATA_WIDTH] <= '0;
`endif
            end
            sensor_stream_ready <= '0;
            sensor_overrun      <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
                if (expiry[k]) begin
`ifdef SENSOR_STREAM_GEN_LFSR_EN
                    sensor_stream[k*DATA_WIDTH +: DATA_WIDTH] <=
                        lfsr_step(sensor_stream[k*DATA_WIDTH +: DATA_WIDTH]);
`else
                    sensor_stream[k*DATA_WIDTH +: DATA_WIDTH] <=
                        sensor_stream[k*DATA_WIDTH +: DATA_WIDTH] + DATA_WIDTH'(k + 1);
`endif
                    sensor_stream_ready[k] <= 1'b1;
                end else if (sensor_stream_ack[k]) begin
                    sensor_stream_ready[k] <= 1'b0;
                end

                // a fresh overwrite beats a coincident clear
                if (expiry[k] && sensor_stream_ready[k] && !sensor_stream_ack[k]) begin
                    sensor_overrun[k] <= 1'b1;
                end else if (overrun_clear) begin
                    sensor_overrun[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sensor_stream_gen.sv
// Testbench for sensor_stream_gen: behavioural model (elapsed-run-tick arithmetic)
// compared every cycle, plus directed literal checks and randomized ack/enable/clear.
module tb_sensor_stream_gen;

    localparam int NCH  = 8;
    localparam int DW   = 8;
    localparam int TW   = 16;
    localparam int BASE = 100;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0;
    logic            overrun_clear = 1'b0;
    logic [NCH-1:0]  ack = '0;
    logic [NCH*DW-1:0] stream;
    logic [NCH-1:0]  ready;
    logic [NCH-1:0]  overrun;
    logic            running;

    always #5 clock = ~clock;

    sensor_stream_gen #(
        .NUM_CHANNELS(NCH),
        .DATA_WIDTH  (DW),
        .TIMER_WIDTH (TW),
        .BASE_PERIOD (BASE)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .enable             (enable),
        .sensor_stream_ack  (ack),
        .overrun_clear      (overrun_clear),
        .sensor_stream      (stream),
        .sensor_stream_ready(ready),
        .sensor_overrun     (overrun),
        .running            (running)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] ch(input int k);
        return stream[k*DW +: DW];
    endfunction

    // ---------------- behavioural model ----------------
    function automatic logic [DW-1:0] model_next(input logic [DW-1:0] v, input int k);
`ifdef SENSOR_STREAM_GEN_LFSR_EN
        logic [7:0] taps;
        taps = 8'hB8;
        return (v >> 1) ^ (v[0] ? taps : 8'h00);
`else
        return v + DW'(k + 1);
`endif
    endfunction

    function automatic logic [DW-1:0] model_seed(input int k);
`ifdef SENSOR_STREAM_GEN_LFSR_EN
        return DW'(k + 1);
`else
        return DW'(k * 0);
`endif
    endfunction

    typedef enum {M_IDLE, M_ARM, M_RUN} mmode_t;
    mmode_t     mmode = M_IDLE;
    int         ticks = 0;
    logic [DW-1:0] m_val [NCH];
    logic [NCH-1:0] m_rdy = '0;
    logic [NCH-1:0] m_ovr = '0;
    bit         m_tick;
    bit         m_exp;

    always begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            mmode = M_IDLE;
            ticks = 0;
            m_rdy = '0;
            m_ovr = '0;
            for (int k = 0; k < NCH; k++) m_val[k] = model_seed(k);
        end else begin
            m_tick = (mmode == M_RUN) && enable;
            if (m_tick) ticks = ticks + 1;
            for (int k = 0; k < NCH; k++) begin
                m_exp = m_tick && ((ticks % (BASE * (k + 1))) == 0);
                if (m_exp && m_rdy[k] && !ack[k]) m_ovr[k] = 1'b1;
                else if (overrun_clear) m_ovr[k] = 1'b0;
                if (m_exp) begin
                    m_val[k] = model_next(m_val[k], k);
                    m_rdy[k] = 1'b1;
                end else if (ack[k]) begin
                    m_rdy[k] = 1'b0;
                end
            end
            case (mmode)
                M_IDLE: if (enable) mmode = M_ARM;
                M_ARM: begin
                    mmode = M_RUN;
                    ticks = 0;
                end
                default: if (!enable) mmode = M_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [NCH*DW-1:0] exp_stream;
    always begin
        @(negedge clock);
        if (reset) begin
            for (int k = 0; k < NCH; k++) exp_stream[k*DW +: DW] = m_val[k];
            check("model_stream",  64'(stream),  64'(exp_stream));
            check("model_ready",   64'(ready),   64'(m_rdy));
            check("model_overrun", 64'(overrun), 64'(m_ovr));
            check("model_running", 64'(running), 64'(mmode == M_RUN));
        end
    end

    // ---------------- ack driver ----------------
    typedef enum {P_AUTO, P_NOACK0, P_MANUAL0, P_RANDOM} policy_t;
    policy_t        policy = P_AUTO;
    logic           force0 = 1'b0;
    logic [NCH-1:0] rmask = '1;

    always begin
        @(posedge clock);
        #1;
        case (policy)
            P_AUTO:    ack = ready;
            P_NOACK0:  ack = ready & ~NCH'(1);
            P_MANUAL0: ack = {ready[NCH-1:1], force0};
            default:   ack = rmask & NCH'($urandom);
        endcase
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    task automatic at_edge(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic wait_running(input string nm, output int base);
        int budget;
        budget = 0;
        while (!running && budget < 10) begin
            @(negedge clock);
            budget++;
        end
        check(nm, 64'(running), 64'd1);
        base = cyc;
    endtask

    int e0, e1;
    logic [DW-1:0] saved, prev;
    int changes;
    bit saw_zero;
    int budget;

    initial begin
        // model pinning
`ifdef SENSOR_STREAM_GEN_LFSR_EN
        check("pin_lfsr_step1", 64'(model_next(8'h01, 0)), 64'hB8);
        check("pin_lfsr_step2", 64'(model_next(8'hB8, 0)), 64'h5C);
`else
        check("pin_ramp_wrap", 64'(model_next(8'hFF, 0)), 64'h00);
        check("pin_ramp_ch3",  64'(model_next(8'd5, 3)),  64'd9);
`endif

        // reset held with enable high
        reset = 1'b0;
        enable = 1'b1;
        repeat (50) @(negedge clock);
`ifdef SENSOR_STREAM_GEN_LFSR_EN
        check("reset_stream", 64'(stream), 64'h0807_0605_0403_0201);
`else
        check("reset_stream", 64'(stream), 64'd0);
`endif
        check("reset_ready",   64'(ready),   64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
        check("reset_running", 64'(running), 64'd0);

        reset = 1'b1;
        @(negedge clock);
        check("arm_not_running", 64'(running), 64'd0);
        @(negedge clock);
        check("run_after_arm", 64'(running), 64'd1);
        e0 = cyc;

        // pacing
        at_edge(e0 + 99);
        check("ch0_before_first", 64'(ready[0]), 64'd0);
`ifndef SENSOR_STREAM_GEN_LFSR_EN
        check("ch0_before_val", 64'(ch(0)), 64'd0);
        at_edge(e0 + 100);
        check("ch0_sample1", 64'(ch(0)), 64'd1);
        at_edge(e0 + 200);
        check("ch0_sample2", 64'(ch(0)), 64'd2);
        at_edge(e0 + 300);
        check("ch0_sample3", 64'(ch(0)), 64'd3);
        at_edge(e0 + 799);
        check("ch7_before_first", 64'(ch(7)), 64'd0);
        at_edge(e0 + 800);
        check("ch7_first", 64'(ch(7)), 64'd8);
        check("ch3_second", 64'(ch(3)), 64'd8);
`endif

        // overrun on channel 0
        at_edge(e0 + 850);
        policy = P_NOACK0;
        at_edge(e0 + 900);
        check("ovr_first_ready", 64'(ready[0]),   64'd1);
        check("ovr_first_flag",  64'(overrun[0]), 64'd0);
        at_edge(e0 + 1000);
        check("ovr_second_ready", 64'(ready[0]),   64'd1);
        check("ovr_second_flag",  64'(overrun[0]), 64'd1);
`ifndef SENSOR_STREAM_GEN_LFSR_EN
        check("ovr_second_val", 64'(ch(0)), 64'd10);
`endif
        at_edge(e0 + 1050);
        overrun_clear = 1'b1;
        at_edge(e0 + 1051);
        overrun_clear = 1'b0;
        check("ovr_cleared", 64'(overrun[0]), 64'd0);
        at_edge(e0 + 1099);
        check("ovr_still_clear", 64'(overrun[0]), 64'd0);
        at_edge(e0 + 1100);
        check("ovr_third_flag", 64'(overrun[0]), 64'd1);

        // ack coincident with expiry
        at_edge(e0 + 1150);
        overrun_clear = 1'b1;
        at_edge(e0 + 1151);
        overrun_clear = 1'b0;
        at_edge(e0 + 1198);
        policy = P_MANUAL0;
        force0 = 1'b1;
        at_edge(e0 + 1199);
        force0 = 1'b0;
        at_edge(e0 + 1200);
        check("simul_ready", 64'(ready[0]),   64'd1);
        check("simul_ovr",   64'(overrun[0]), 64'd0);
`ifndef SENSOR_STREAM_GEN_LFSR_EN
        check("simul_val", 64'(ch(0)), 64'd12);
`endif

        // pause / resume
        at_edge(e0 + 1250);
        policy = P_AUTO;
        saved = ch(0);
        enable = 1'b0;
        repeat (37) @(negedge clock);
        check("pause_val_held", 64'(ch(0)), 64'(saved));
        check("pause_not_running", 64'(running), 64'd0);
        enable = 1'b1;
        wait_running("resume_running", e1);
        at_edge(e1 + 99);
        check("resume_before", 64'(ch(0)), 64'(saved));
        at_edge(e1 + 100);
        check("resume_sample", 64'(ch(0)), 64'(model_next(saved, 0)));

        // randomized acks, clears and enable drops
        policy = P_RANDOM;
        repeat (6000) begin
            @(negedge clock);
            if ($urandom_range(0, 499) == 0) rmask = NCH'($urandom);
            overrun_clear = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 399) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 60)) @(negedge clock);
                enable = 1'b1;
            end
        end
        overrun_clear = 1'b0;
        policy = P_AUTO;
        repeat (5) @(negedge clock);
        overrun_clear = 1'b1;
        @(negedge clock);
        overrun_clear = 1'b0;

        // long channel-0 run: ramp wraps, or LFSR never hits zero
`ifdef SENSOR_STREAM_GEN_LFSR_EN
        begin
            int target;
            target = 300;
`else
        begin
            int target;
            target = 256;
`endif
            saved = ch(0);
            changes = 0;
            saw_zero = 1'b0;
            while (changes < target) begin
                prev = ch(0);
                budget = 0;
                while (ch(0) == prev && budget < 250) begin
                    @(negedge clock);
                    budget++;
                end
                if (ch(0) == prev) begin
                    check("long_run_timeout", 64'(ch(0)), 64'(model_next(prev, 0)));
                    break;
                end
                changes++;
                if (ch(0) == '0) saw_zero = 1'b1;
            end
            check("long_run_count",   64'(changes),    64'(target));
            check("long_run_overrun", 64'(overrun[0]), 64'd0);
`ifdef SENSOR_STREAM_GEN_LFSR_EN
            check("lfsr_no_zero", 64'(saw_zero), 64'd0);
`else
            check("wrap_returns", 64'(ch(0)), 64'(saved));
            check("wrap_saw_zero", 64'(saw_zero), 64'd1);
`endif
        end

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sensor_stream_gen.md
Name: sensor_stream_gen

Overview:
Parametrised synthetic sensor source that replaces the fixed 8-channel analog sensor model. It generates NUM_CHANNELS independent sample streams of DATA_WIDTH bits, each paced by its own period timer. Each stream has a ready/ack handshake and sticky overrun detection. It feeds the stream-select/packetiser path ahead of the Bluetooth UART, in simulation and on the FPGA.

Parameters:
NUM_CHANNELS, 8, number of sensor streams (1..16)
DATA_WIDTH, 16, bits per sample (8..32)
TIMER_WIDTH, 16, width of per-channel period counters
BASE_PERIOD, 100, clock cycles between samples on channel 0; channel k period = BASE_PERIOD*(k+1); must satisfy NUM_CHANNELS*BASE_PERIOD < 2^TIMER_WIDTH

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  1 = streams run; 0 = timers frozen
sensor_stream_ack  in  NUM_CHANNELS  per-channel consume strobe, one cycle
overrun_clear  in  1  clears all overrun flags
sensor_stream  out  NUM_CHANNELS*DATA_WIDTH  flat sample bus; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
sensor_stream_ready  out  NUM_CHANNELS  sample valid, held until ack
sensor_overrun  out  NUM_CHANNELS  sticky: a sample was overwritten before ack
running  out  1  FSM in RUN

Behaviour:
- Reset (reset=0, async): sensor_stream=0, sensor_stream_ready=0, sensor_overrun=0, running=0, all timers=0, FSM=IDLE.
- FSM has 3 states:
  - IDLE: running=0; timers hold. enable=1 -> ARM.
  - ARM: one cycle; loads each timer k with period_k-1; -> RUN.
  - RUN: running=1; enable=0 -> IDLE, with timers held at their current count, not reloaded on re-entry through ARM? No — re-entry always passes ARM, which reloads all timers.
- In RUN, timer k decrements each cycle. When it equals 0 (expiry):
  - reload period_k-1 next cycle;
  - sample register k <= sample_k + (k+1), modulo 2^DATA_WIDTH, wrapping silently;
  - ready_k <= 1.
- Sample timing: first sample on channel k appears exactly period_k cycles after the ARM cycle. Subsequent samples follow every period_k cycles.
- Ready/ack:
  - ack_k while ready_k=1 and no expiry -> ready_k=0 next cycle;
  - ack_k while ready_k=0 is ignored.
- Expiry with ready_k=1 and no ack_k in the same cycle: the sample is overwritten, ready_k stays 1, overrun_k <= 1 (sticky).
- Expiry and ack_k in the same cycle: the new sample loads, ready_k stays 1, no overrun.
- overrun_clear: clears all overrun bits next cycle. A coincident new overrun event on channel k wins, so overrun_k = 1.
- enable drop mid-run: samples and ready bits are held, and acks are still honoured in IDLE.
- Sample values persist across IDLE/RUN cycles; only reset zeroes them.
- All outputs are registered; no combinational input-to-output path.

Optional Feature:
Macro SENSOR_STREAM_GEN_LFSR_EN.
- Defined: each channel's next sample is a DATA_WIDTH Galois LFSR step instead of the ramp increment.
  - Taps: a maximal-length table for widths 8..32.
  - Seed: value (k+1) loaded on reset; state 0 is unreachable.
- Undefined: ramp behaviour as above; no LFSR logic is synthesised.

Test Plan:
- Reset: hold reset=0 for 50 cycles with enable=1 -> all outputs 0 and running=0. Release -> running=1 two cycles later (IDLE->ARM->RUN).
- Pacing (defaults): enable=1, ack every ready the cycle after it rises -> channel 0 samples 1,2,3 at cycles 100,200,300 after ARM. Channel 7 first sample is 8, at cycle 800. Channel 3 second sample is 8.
- Overrun: never ack channel 0 -> at the 2nd expiry sensor_overrun[0]=1, value=2, ready[0]=1. Assert overrun_clear -> overrun[0]=0 until the 3rd expiry, then 1 again.
- Simultaneous: assert ack[0] exactly on the expiry cycle -> ready[0] stays 1, overrun[0] stays 0, value increments.
- Wrap: DATA_WIDTH=8 with channel 0 -> after 256 samples the value returns to 0, with no overrun when acked.
- Pause/resume: drop enable mid-period for 37 cycles, then re-raise -> samples and ready unchanged during the pause, and the next sample on channel k arrives period_k cycles after the new ARM. With SENSOR_STREAM_GEN_LFSR_EN defined, the channel 0 sequence matches the LFSR reference model for 300 samples with no zero value.
